// File: rtl/piezo_tune_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piezo_tune_if : go/mode request and tone/status outputs of the       |
// |                 piezo tune sequencer.            Revision 1.0         |
// +----------------------------------------------------------------------+
interface piezo_tune_if;
  logic       go;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic       piezo;
  logic       piezo_n;

  modport master (output go, output mode,
                  input  busy, input done, input piezo, input piezo_n);
  modport slave  (input  go, input mode,
                  output busy, output done, output piezo, output piezo_n);
endinterface
`default_nettype wire

// File: rtl/piezo_tune_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piezo_tune_seq : plays one of four note sequences on a complementary |
// |                  piezo pair.                     Revision 1.0         |
// +----------------------------------------------------------------------+
module piezo_tune_seq #(
  parameter int unsigned DUR_SHIFT = 0,
  parameter int unsigned HP_SHIFT  = 0,
  parameter int unsigned REPEATS   = 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  piezo_tune_if.slave bus
);

  localparam logic [1:0]  c_MODE_FANFARE = 2'b01;
  localparam logic [1:0]  c_MODE_ERROR   = 2'b10;
  localparam logic [1:0]  c_MODE_DONE    = 2'b11;
  localparam logic [25:0] c_DUR_2P22     = 26'd4194304;
  localparam logic [25:0] c_DUR_2P23     = 26'd8388608;
  localparam logic [25:0] c_DUR_2P25     = 26'd33554432;
  localparam logic [2:0]  c_REP_LAST     = 3'(REPEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  mode_q;
  logic [2:0]  idx_q;
  logic [2:0]  rep_q;
  logic [25:0] dur_q;
  logic [13:0] hp_q;
  logic        busy_q;
  logic        done_q;
  logic        piezo_q;
  logic        piezo_n_q;

  // Duration counters load D-1 and count down, so a segment lasts exactly D cycles.
  function automatic logic [25:0] dur_m1(input logic [2:0] note, input logic err);
    logic [25:0] base;
    logic [25:0] eff;
    if (err) begin
      base = c_DUR_2P22;
    end else begin
      case (note)
        3'd3:    base = c_DUR_2P23 + c_DUR_2P22;
        3'd4:    base = c_DUR_2P22;
        3'd5:    base = c_DUR_2P25;
        default: base = c_DUR_2P23;
      endcase
    end
    eff = base >> DUR_SHIFT;
    return (eff == 26'd0) ? 26'd0 : eff - 26'd1;
  endfunction

  function automatic logic [13:0] hp_m1(input logic [2:0] note);
    logic [13:0] base;
    logic [13:0] eff;
    case (note)
      3'd0:      base = 14'd15944;
      3'd1:      base = 14'd11945;
      3'd2, 3'd4: base = 14'd9480;
      default:   base = 14'd7972;
    endcase
    eff = base >> HP_SHIFT;
    return (eff == 14'd0) ? 14'd0 : eff - 14'd1;
  endfunction

  logic        w_err_mode;
  logic        w_done_mode;
  logic        w_seg_end;
  logic        w_gap_next;
  logic [2:0]  w_note;
  logic [2:0]  w_next_idx;
  logic [13:0] w_hp_m1;
  logic [25:0] w_gap_m1;

  always_comb begin
    w_err_mode  = (mode_q == c_MODE_ERROR);
    w_done_mode = (mode_q == c_MODE_DONE);
    w_note      = w_err_mode ? 3'd0 : idx_q;
    w_hp_m1     = hp_m1(w_note);
    w_gap_m1    = dur_m1(3'd0, 1'b1);
    w_next_idx  = idx_q + 3'd1;
    case (mode_q)
      c_MODE_FANFARE: w_seg_end = (idx_q == 3'd2);
      c_MODE_ERROR:   w_seg_end = 1'b1;
      default:        w_seg_end = (idx_q == 3'd5);
    endcase
    // ERROR uses idx_q as a step counter: step 0 is followed by the gap.
    w_gap_next = (w_err_mode && (idx_q == 3'd0)) ||
                 (w_done_mode && (rep_q != c_REP_LAST));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= 2'b00;
      idx_q     <= 3'd0;
      rep_q     <= 3'd0;
      dur_q     <= 26'd0;
      hp_q      <= 14'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      piezo_q   <= 1'b0;
      piezo_n_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.go) begin
            state_q   <= S_TONE;
            mode_q    <= bus.mode;
            idx_q     <= 3'd0;
            rep_q     <= 3'd0;
            dur_q     <= dur_m1(3'd0, bus.mode == c_MODE_ERROR);
            hp_q      <= 14'd0;
            busy_q    <= 1'b1;
            piezo_q   <= 1'b0;
            piezo_n_q <= 1'b1;
          end
        end
        S_TONE: begin
          if (dur_q != 26'd0) begin
            dur_q <= dur_q - 26'd1;
            if (hp_q == w_hp_m1) begin
              hp_q      <= 14'd0;
              piezo_q   <= ~piezo_q;
              piezo_n_q <= ~piezo_n_q;
            end else begin
              hp_q <= hp_q + 14'd1;
            end
          end else if (!w_seg_end) begin
            idx_q     <= w_next_idx;
            dur_q     <= dur_m1(w_next_idx, w_err_mode);
            hp_q      <= 14'd0;
            piezo_q   <= 1'b0;
            piezo_n_q <= 1'b1;
          end else if (w_gap_next) begin
            state_q   <= S_GAP;
            dur_q     <= w_gap_m1;
            hp_q      <= 14'd0;
            piezo_q   <= 1'b0;
            piezo_n_q <= 1'b0;
          end else begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            piezo_q   <= 1'b0;
            piezo_n_q <= 1'b0;
          end
        end
        S_GAP: begin
          if (dur_q != 26'd0) begin
            dur_q <= dur_q - 26'd1;
          end else begin
            state_q   <= S_TONE;
            idx_q     <= w_err_mode ? 3'd1 : 3'd0;
            dur_q     <= dur_m1(3'd0, w_err_mode);
            hp_q      <= 14'd0;
            piezo_q   <= 1'b0;
            piezo_n_q <= 1'b1;
            if (w_done_mode) begin
              rep_q <= rep_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.piezo   = piezo_q;
  assign bus.piezo_n = piezo_n_q;

endmodule
`default_nettype wire

// File: tb/tb_piezo_tune_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_piezo_tune_seq : scoreboard bench for piezo_tune_seq.              |
// |                                                  Revision 1.0         |
// +----------------------------------------------------------------------+
module tb_piezo_tune_seq;

  // Durations are scaled by 2^12 so the whole run stays short.
  localparam int DS  = 12;
  localparam int HS  = 4;
  localparam int REP = 2;

  typedef struct {
    int len;
    int silent;
    int first_hp;
    int rises;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  piezo_tune_if bus ();

  piezo_tune_seq #(
    .DUR_SHIFT (DS),
    .HP_SHIFT  (HS),
    .REPEATS   (REP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];
  exp_t e_charge, e_fanfare, e_error, e_done;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Rising edges of piezo in one note: toggle k lands at k*HP and only counts if k*HP < D.
  function automatic int rises(input int d, input int hp);
    int t;
    t = (d - 1) / hp;
    return (t + 1) / 2;
  endfunction

  // ---------------- monitor ----------------
  int   m_len = 0, m_sil = 0, m_fhp = -1, m_rise = 0, m_cerr = 0, n_done = 0;
  bit   m_act = 1'b0, m_prev = 1'b0;
  exp_t m_e;

  always @(negedge clk) begin
    if (rst) begin
      m_act  = 1'b0;
      m_prev = 1'b0;
    end else begin
      if (bus.busy) begin
        if (!m_act) begin
          m_act = 1'b1; m_len = 0; m_sil = 0; m_fhp = -1; m_rise = 0; m_cerr = 0;
        end
        m_len++;
        if (!bus.piezo && !bus.piezo_n) m_sil++;
        else if (bus.piezo_n == bus.piezo) m_cerr++;
        if (bus.piezo && !m_prev) begin
          m_rise++;
          if (m_fhp < 0) m_fhp = m_len - 1;
        end
      end
      if (bus.done) begin
        n_done++;
        if (sb_q.size() == 0) begin
          check("done_with_empty_scoreboard", sb_q.size(), 1);
        end else begin
          m_e = sb_q.pop_front();
          check("busy_length",        m_len,  m_e.len);
          check("silent_cycles",      m_sil,  m_e.silent);
          check("first_half_period",  m_fhp,  m_e.first_hp);
          check("piezo_rising_edges", m_rise, m_e.rises);
          check("complement_errors",  m_cerr, 0);
        end
        check("quiet_at_done", int'(bus.piezo | bus.piezo_n), 0);
        check("busy_at_done",  int'(bus.busy), 0);
        m_act = 1'b0;
      end
      m_prev = bus.piezo;
    end
  end

  // ---------------- stimulus ----------------
  task automatic start(input logic [1:0] m);
    @(negedge clk);
    bus.go   = 1'b1;
    bus.mode = m;
    @(negedge clk);
    bus.go   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check({name, "_done_seen"}, int'(seen), 1);
  endtask

  initial begin
    int d [6];
    int hp[6];
    int de, dg;

    d  = '{(1 << 23) >> DS, (1 << 23) >> DS, (1 << 23) >> DS,
           ((1 << 23) + (1 << 22)) >> DS, (1 << 22) >> DS, (1 << 25) >> DS};
    hp = '{15944 >> HS, 11945 >> HS, 9480 >> HS, 7972 >> HS, 9480 >> HS, 7972 >> HS};
    de = (1 << 22) >> DS;
    dg = (1 << 22) >> DS;

    e_charge  = '{0, 0, hp[0], 0};
    e_fanfare = '{0, 0, hp[0], 0};
    for (int i = 0; i < 6; i++) begin
      e_charge.len   += d[i];
      e_charge.rises += rises(d[i], hp[i]);
      if (i < 3) begin
        e_fanfare.len   += d[i];
        e_fanfare.rises += rises(d[i], hp[i]);
      end
    end
    e_error = '{3 * de, de, hp[0], 2 * rises(de, hp[0])};
    e_done  = '{REP * e_charge.len + (REP - 1) * dg, (REP - 1) * dg, hp[0],
                REP * e_charge.rises};

    rst      = 1'b1;
    bus.go   = 1'b0;
    bus.mode = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_busy",    int'(bus.busy),    0);
    check("reset_done",    int'(bus.done),    0);
    check("reset_piezo",   int'(bus.piezo),   0);
    check("reset_piezo_n", int'(bus.piezo_n), 0);
    rst = 1'b0;

    // Abort a CHARGE play with an asynchronous reset.
    start(2'b00);
    repeat (2000) @(negedge clk);
    check("sounding_before_reset", int'(bus.piezo | bus.piezo_n), 1);
    #2 rst = 1'b1;
    #1;
    check("midtune_reset_busy",    int'(bus.busy),    0);
    check("midtune_reset_piezo",   int'(bus.piezo),   0);
    check("midtune_reset_piezo_n", int'(bus.piezo_n), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    sb_q.push_back(e_charge);
    start(2'b00);
    wait_done(e_charge.len + 50, "charge");

    // Stray go pulses with another mode must not disturb FANFARE.
    sb_q.push_back(e_fanfare);
    start(2'b01);
    repeat (3) begin
      repeat (1500) @(negedge clk);
      bus.go   = 1'b1;
      bus.mode = 2'b10;
      @(negedge clk);
      bus.go   = 1'b0;
    end
    wait_done(e_fanfare.len + 50, "fanfare");

    // go in the done cycle is accepted immediately.
    sb_q.push_back(e_error);
    bus.go   = 1'b1;
    bus.mode = 2'b10;
    @(negedge clk);
    bus.go   = 1'b0;
    check("back_to_back_busy", int'(bus.busy), 1);
    wait_done(e_error.len + 50, "error");

    sb_q.push_back(e_done);
    start(2'b11);
    wait_done(e_done.len + 50, "done_mode");

    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("done_pulse_count",   n_done, 4);
    check("idle_busy",          int'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
